// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch_queue, the program ROM and the core front end.
// The master modport is the queue side; slave is the ROM/core side.
interface fetch_queue_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic              fetch_en;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [XLEN-1:0]   rom_data;
    logic              instr_valid;
    logic [XLEN-1:0]   instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CntW-1:0]   occupancy;

    modport master (
        input  fetch_en, rom_data, instr_ready, redirect_valid, redirect_pc,
        output rom_req, rom_addr, instr_valid, instr, instr_pc, occupancy
    );

    modport slave (
        output fetch_en, rom_data, instr_ready, redirect_valid, redirect_pc,
        input  rom_req, rom_addr, instr_valid, instr, instr_pc, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO fed by a one-cycle-latency ROM, flushed on redirect.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to the head when empty.
module fetch_queue #(
    parameter int unsigned       XLEN     = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic              inflight_q, inflight_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   occ_q, occ_d;
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [XLEN-1:0]   data_d [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [ADDR_W-1:0] pc_d [DEPTH];

    logic req, resp_ok, bypass, q_empty, push, pop;
    logic unused_redirect_pc;

    assign unused_redirect_pc = ^bus.redirect_pc[1:0];

    // No separate drop flag: a redirect blocks the request in its own cycle, so the only
    // response it can meet arrives in that same cycle and is discarded via resp_ok.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.fetch_en)  state_d = StRun;
            StRun:  if (!bus.fetch_en) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        q_empty = (occ_q == '0);
        req     = (state_q == StRun) && !bus.redirect_valid &&
                  ((occ_q + CntW'(inflight_q)) < CntW'(DEPTH));
        resp_ok = inflight_q && !bus.redirect_valid;

        bus.instr_valid = !q_empty;
        bus.instr       = '0;
        bus.instr_pc    = '0;
        if (!q_empty) begin
            bus.instr    = data_q[rd_ptr_q];
            bus.instr_pc = pc_q[rd_ptr_q];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = resp_ok && q_empty;
        if (bypass) begin
            bus.instr_valid = 1'b1;
            bus.instr       = bus.rom_data;
            bus.instr_pc    = resp_pc_q;
        end
`else
        bypass = 1'b0;
`endif

        pop  = !q_empty && bus.instr_ready && !bus.redirect_valid;
        push = resp_ok && !(bypass && bus.instr_ready);

        data_d   = data_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            data_d[wr_ptr_q] = bus.rom_data;
            pc_d[wr_ptr_q]   = resp_pc_q;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push && !pop)      occ_d = occ_q + CntW'(1);
        else if (pop && !push) occ_d = occ_q - CntW'(1);

        inflight_d = req;
        resp_pc_d  = req ? fetch_pc_q : resp_pc_q;
        fetch_pc_d = req ? fetch_pc_q + ADDR_W'(XLEN / 8) : fetch_pc_q;

        if (bus.redirect_valid) begin
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        end

        bus.rom_req   = req;
        bus.rom_addr  = fetch_pc_q;
        bus.occupancy = occ_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        pc_q   <= pc_d;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus reset and wrap sequences.
module tb_fetch_queue;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic clk = 1'b0;
    logic reset;
    logic reset_w;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32), .ADDR_W(32), .DEPTH(4)) bus ();
    fetch_queue_if #(.XLEN(32), .ADDR_W(8),  .DEPTH(4)) bus_w ();

    fetch_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    fetch_queue #(.XLEN(32), .ADDR_W(8), .DEPTH(4), .RESET_PC(8'hF8)) u_wrap (
        .clk   (clk),
        .reset (reset_w),
        .bus   (bus_w.master)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [4:0] rd;
        rd = a[6:2] + 5'd5;
        return {a[11:0], 5'd0, 3'b000, rd, 7'h13};
    endfunction

    // One-cycle-latency ROM models
    always @(posedge clk) if (bus.rom_req)   bus.rom_data   <= rom_word(bus.rom_addr);
    always @(posedge clk) if (bus_w.rom_req) bus_w.rom_data <= rom_word({24'd0, bus_w.rom_addr});

    typedef struct {
        bit          rst, fen, rdy, rdr;
        logic [31:0] rpc;
        bit          req, ca;
        logic [31:0] addr;
        bit          vld;
        logic [31:0] pc;
        int          occ;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input bit rst, fen, rdy, rdr, input logic [31:0] rpc, input bit req,
                       ca, input logic [31:0] addr, input bit vld, input logic [31:0] pc,
                       input int occ);
        vec_t v;
        v = '{rst, fen, rdy, rdr, rpc, req, ca, addr, vld, pc, occ};
        vecs.push_back(v);
    endtask

    task automatic check(input string what, input int row, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", what, row, act, exp);
        end
    endtask

    logic [31:0] wrap_pc [4];
    bit          prev_req;

    initial begin
        reset = 1'b1;
        reset_w = 1'b1;
        bus.fetch_en = 1'b0; bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus_w.fetch_en = 1'b0; bus_w.instr_ready = 1'b0;
        bus_w.redirect_valid = 1'b0; bus_w.redirect_pc = '0;
        wrap_pc[0] = 32'hF8; wrap_pc[1] = 32'hFC; wrap_pc[2] = 32'h00; wrap_pc[3] = 32'h04;

        //   rst fen rdy rdr rpc      req ca addr    vld pc       occ
        add(N, Y, Y, N, 32'h0,   N, Y, 32'h0,   N, 32'h0,   0); // c0 IDLE
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h0,   N, 32'h0,   0); // c1 first request
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h4,   N, 32'h0,   0);
        for (int k = 0; k < 8; k++)                                      // c3..c10 stream
            add(N, Y, Y, N, 32'h0, Y, N, 32'(8 + 4 * k), Y, 32'(4 * k), 1);
        add(N, N, N, N, 32'h0,   Y, N, 32'h28,  Y, 32'h20,  1); // c11 still RUN
        add(N, N, N, N, 32'h0,   N, N, 32'h0,   Y, 32'h20,  2); // c12 in-flight kept
        add(N, N, N, N, 32'h0,   N, N, 32'h0,   Y, 32'h20,  3);
        add(N, Y, Y, Y, 32'h42,  N, N, 32'h0,   Y, 32'h20,  3); // c14 redirect + pop
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h40,  N, 32'h0,   0);
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h44,  N, 32'h0,   0);
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h48,  Y, 32'h40,  1);
        add(N, Y, Y, Y, 32'h102, N, N, 32'h0,   Y, 32'h44,  1); // c18 drops 0x48 response
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h100, N, 32'h0,   0);
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h104, N, 32'h0,   0);
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h108, Y, 32'h100, 1);
        add(N, Y, N, N, 32'h0,   Y, N, 32'h10C, Y, 32'h104, 1); // c22 stall
        add(N, Y, N, N, 32'h0,   Y, N, 32'h110, Y, 32'h104, 2);
        add(N, Y, N, N, 32'h0,   N, N, 32'h0,   Y, 32'h104, 3); // credits exhausted
        add(N, Y, N, N, 32'h0,   N, N, 32'h0,   Y, 32'h104, 4);
        add(N, Y, Y, N, 32'h0,   N, N, 32'h0,   Y, 32'h104, 4); // c26 release
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h114, Y, 32'h108, 3);
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h118, Y, 32'h10C, 2);
        add(N, Y, N, N, 32'h0,   Y, N, 32'h11C, Y, 32'h110, 2);
        add(Y, Y, N, N, 32'h0,   N, N, 32'h0,   Y, 32'h110, 3); // c30 reset mid-stream
        add(N, Y, Y, N, 32'h0,   N, Y, 32'h0,   N, 32'h0,   0);
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h0,   N, 32'h0,   0);
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h4,   N, 32'h0,   0);
        add(N, Y, Y, N, 32'h0,   Y, N, 32'h8,   Y, 32'h0,   1);

        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset rom_req",     -1, 64'(bus.rom_req),     64'd0);
        check("reset rom_addr",    -1, 64'(bus.rom_addr),    64'd0);
        check("reset instr_valid", -1, 64'(bus.instr_valid), 64'd0);
        check("reset instr",       -1, 64'(bus.instr),       64'd0);
        check("reset instr_pc",    -1, 64'(bus.instr_pc),    64'd0);
        check("reset occupancy",   -1, 64'(bus.occupancy),   64'd0);

        prev_req = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset              = vecs[i].rst;
            bus.fetch_en       = vecs[i].fen;
            bus.instr_ready    = vecs[i].rdy;
            bus.redirect_valid = vecs[i].rdr;
            bus.redirect_pc    = vecs[i].rpc;
            #1;
            check("rom_req", i, 64'(bus.rom_req), 64'(vecs[i].req));
            if (vecs[i].req || vecs[i].ca)
                check("rom_addr", i, 64'(bus.rom_addr), 64'(vecs[i].addr));
            check("instr_valid", i, 64'(bus.instr_valid), 64'(vecs[i].vld));
            check("occupancy", i, 64'(bus.occupancy), 64'(vecs[i].occ));
            if (vecs[i].vld) begin
                check("instr_pc", i, 64'(bus.instr_pc), 64'(vecs[i].pc));
                check("instr", i, 64'(bus.instr), 64'(rom_word(vecs[i].pc)));
            end
            check("no_overflow", i,
                  64'(prev_req && !vecs[i].rdr && !vecs[i].rst && bus.occupancy == 3'd4 &&
                      !(bus.instr_valid && vecs[i].rdy)), 64'd0);
            prev_req = bus.rom_req;
        end

        // Address wrap on the 8-bit instance
        @(negedge clk);
        reset_w = 1'b1;
        @(negedge clk);
        reset_w = 1'b0;
        bus_w.fetch_en = 1'b1;
        bus_w.instr_ready = 1'b1;
        #1;
        check("wrap idle rom_addr", 0, 64'(bus_w.rom_addr), 64'hF8);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) check("wrap rom_addr", k, 64'(bus_w.rom_addr), 64'hF8);
            if (k == 3) check("wrap rom_addr", k, 64'(bus_w.rom_addr), 64'h00);
            if (k >= 3) begin
                check("wrap instr_valid", k, 64'(bus_w.instr_valid), 64'd1);
                check("wrap instr_pc", k, 64'(bus_w.instr_pc), 64'(wrap_pc[k-3]));
                check("wrap instr", k, 64'(bus_w.instr), 64'(rom_word(wrap_pc[k-3])));
            end else begin
                check("wrap instr_valid", k, 64'(bus_w.instr_valid), 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
